// File: rtl/tracer_rd_if.sv
// tracer_rd_if: reads previously captured trace words back from L2 through a
// uDMA TX channel. Returned words are buffered in a small FIFO and presented to
// a trace decoder as a valid/ready word stream.
//
// Requests are only issued while the FIFO has room for every word already
// requested, so returned data can always be accepted (data_tx_ready_o is tied
// high).
//
// Optional feature, enabled by defining TRACER_RD_STATS_EN:
//   - adds output stat_words_o, a free-running count of words popped downstream
//     since reset.
module tracer_rd_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [TRANS_SIZE-1:0] word_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  data_tx_req_o,
    input  logic                  data_tx_gnt_i,
    output logic [1:0]            data_tx_datasize_o,
    input  logic [31:0]           data_tx_i,
    input  logic                  data_tx_valid_i,
    output logic                  data_tx_ready_o,
    output logic [31:0]           trdb_packet_o,
    output logic                  trdb_word_valid_o,
    input  logic                  trdb_word_ready_i
`ifdef TRACER_RD_STATS_EN
    ,
    output logic [31:0]           stat_words_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int UW = OW + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_done;

    logic [TRANS_SIZE-1:0] r_req_left;
    logic [OW-1:0]         r_outstanding;
    logic [OW-1:0]         r_count;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [31:0]           w_entries [FIFO_DEPTH];

    logic                  w_active;
    logic [UW-1:0]         w_used;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_rsp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_clear;

    // Words in flight (in the FIFO or still owed by the uDMA) bound the credit.
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_used   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req    = (r_state == S_RUN) && (r_req_left != '0) && (w_used < DEPTH_U);
    assign w_grant  = w_req && data_tx_gnt_i;
    // A response is only meaningful when a word is actually owed to us.
    assign w_rsp    = data_tx_valid_i && (r_outstanding != '0) && (r_state != S_IDLE);
    assign w_clear  = (w_active && abort_i) || (r_state == S_FLUSH);
    assign w_push   = w_rsp && w_active && !abort_i;
    assign w_pop    = trdb_word_valid_o && trdb_word_ready_i;

    assign busy_o             = (r_state != S_IDLE);
    assign done_o             = w_done;
    assign data_tx_req_o      = w_req;
    assign data_tx_datasize_o = 2'b10;
    assign data_tx_ready_o    = 1'b1;
    assign trdb_word_valid_o  = w_active && (r_count != '0);
    assign trdb_packet_o      = w_entries[r_rptr];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and completion pulse; abort wins over a same-cycle completion.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = (word_cnt_i == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_state_next = S_FLUSH;
                end else if (w_grant && (r_req_left == TRANS_SIZE'(1))) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    w_state_next = S_FLUSH;
                end else if ((r_outstanding == '0) && (r_count == '0) && !w_push) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_outstanding == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Remaining words to request: loaded on start, decremented per grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_left <= '0;
        end else if (w_clear) begin
            r_req_left <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_req_left <= word_cnt_i;
        end else if (w_grant) begin
            r_req_left <= r_req_left - TRANS_SIZE'(1);
        end
    end

    // Granted-but-not-returned words; a same-cycle grant and response cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide even when full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + OW'(w_push) - OW'(w_pop);
        end
    end

    // FIFO storage: one register per slot so the head is visible the cycle after a push.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        logic [31:0] r_entry;

        // Slot captures the returned word when the write pointer addresses it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_entry <= '0;
            end else if (w_push && (r_wptr == AW'(gi))) begin
                r_entry <= data_tx_i;
            end
        end

        assign w_entries[gi] = r_entry;
    end

`ifdef TRACER_RD_STATS_EN
    logic [31:0] r_stat_words;

    // Lifetime count of words handed downstream; wraps naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_words <= '0;
        end else if (w_pop) begin
            r_stat_words <= r_stat_words + 32'd1;
        end
    end

    assign stat_words_o = r_stat_words;
`endif

`ifndef SYNTHESIS
    // Data must never arrive without a matching earlier grant while reading.
    a_no_orphan_data: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_tx_valid_i && w_active) |-> (r_outstanding != '0));
`endif

endmodule

// File: tb/tb_tracer_rd_if.sv
module tb_tracer_rd_if;

    localparam int DEPTH = 4;
    localparam int TS    = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [TS-1:0] word_cnt_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          data_tx_req_o;
    logic          data_tx_gnt_i = 1'b0;
    logic [1:0]    data_tx_datasize_o;
    logic [31:0]   data_tx_i = '0;
    logic          data_tx_valid_i = 1'b0;
    logic          data_tx_ready_o;
    logic [31:0]   trdb_packet_o;
    logic          trdb_word_valid_o;
    logic          trdb_word_ready_i = 1'b0;
`ifdef TRACER_RD_STATS_EN
    logic [31:0]   stat_words_o;
`endif

    tracer_rd_if #(.FIFO_DEPTH(DEPTH), .TRANS_SIZE(TS)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .word_cnt_i         (word_cnt_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .data_tx_req_o      (data_tx_req_o),
        .data_tx_gnt_i      (data_tx_gnt_i),
        .data_tx_datasize_o (data_tx_datasize_o),
        .data_tx_i          (data_tx_i),
        .data_tx_valid_i    (data_tx_valid_i),
        .data_tx_ready_o    (data_tx_ready_o),
        .trdb_packet_o      (trdb_packet_o),
        .trdb_word_valid_o  (trdb_word_valid_o),
        .trdb_word_ready_i  (trdb_word_ready_i)
`ifdef TRACER_RD_STATS_EN
        ,
        .stat_words_o       (stat_words_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: uDMA memory side and downstream expectations.
    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        pend_q[$];
    logic [31:0] exp_q[$];
    rsp_t        rsp;
    int          gnt_mode   = 0;       // 0: grant whenever asked, 1: random
    int          gnt_cap    = 1 << 30; // stop granting after this many per read
    int          dly_min    = 1;
    int          dly_max    = 1;
    int          rdy_mode   = 0;       // 0: low, 1: high, 2: random
    bit          seq_mode   = 1'b0;
    logic [31:0] seq_base   = '0;
    bit          discard    = 1'b0;
    bit          flushing   = 1'b0;
    int          txn_grants = 0;
    int          txn_pops   = 0;
    int          tot_pops   = 0;
    int          done_cnt   = 0;
    int          done_cyc   = 0;
    int          start_cyc  = 0;
    int          d0         = 0;

    // uDMA model: grants requests, returns each word after a delay, in order.
    initial begin
        forever begin
            @(negedge clk_i);
            if (gnt_mode == 0) data_tx_gnt_i = (txn_grants < gnt_cap);
            else               data_tx_gnt_i = ($urandom_range(0, 1) == 1) && (txn_grants < gnt_cap);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                data_tx_valid_i = 1'b1;
                data_tx_i       = pend_q[0].data;
            end else begin
                data_tx_valid_i = 1'b0;
                data_tx_i       = $urandom;
            end
            #1;
            if (data_tx_valid_i && data_tx_ready_o && pend_q.size() > 0) void'(pend_q.pop_front());
            if (data_tx_req_o && data_tx_gnt_i) begin
                rsp.data = seq_mode ? (seq_base + 32'(txn_grants)) : $urandom;
                rsp.due  = cyc + $urandom_range(dly_min, dly_max);
                pend_q.push_back(rsp);
                txn_grants++;
                if (!discard) begin
                    exp_q.push_back(rsp.data);
                    check("credit_limit", 32'(txn_grants - txn_pops <= DEPTH), 32'd1);
                end
            end
        end
    end

    // Downstream ready driver.
    initial begin
        forever begin
            @(negedge clk_i);
            case (rdy_mode)
                1:       trdb_word_ready_i = 1'b1;
                2:       trdb_word_ready_i = ($urandom_range(0, 1) == 1);
                default: trdb_word_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares every delivered word against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (trdb_word_valid_o && trdb_word_ready_i) begin
                txn_pops++;
                tot_pops++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL word: got 0x%08h, expected no word (cycle %0d)", trdb_packet_o, cyc);
                end else begin
                    check("word", trdb_packet_o, exp_q.pop_front());
                end
            end
            if (flushing) check("flush_valid", 32'(trdb_word_valid_o), 32'd0);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_read(input int cnt);
        @(negedge clk_i);
        txn_grants = 0;
        txn_pops   = 0;
        discard    = 1'b0;
        start_i    = 1'b1;
        word_cnt_i = TS'(cnt);
        start_cyc  = cyc;
        d0         = done_cnt;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
            #2;
        end
    endtask

    task automatic finish_read(input string name, input int cnt);
        bit ok;
        #2;
        wait_done(3000, ok);
        check({name, "_done_seen"}, 32'(ok), 32'd1);
        @(negedge clk_i);
        #1;
        check({name, "_busy_after"}, 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
        #2;
        check({name, "_grants"}, 32'(txn_grants), 32'(cnt));
        check({name, "_delivered"}, 32'(txn_pops), 32'(cnt));
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        $display("[TB] read %s: cnt=%0d grants=%0d delivered=%0d", name, cnt, txn_grants, txn_pops);
    endtask

    initial begin
        bit ok;

        // Reset state.
        @(negedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_req", 32'(data_tx_req_o), 32'd0);
        check("rst_valid", 32'(trdb_word_valid_o), 32'd0);
        check("rst_packet", trdb_packet_o, 32'd0);
        check("rst_ready", 32'(data_tx_ready_o), 32'd1);
        check("rst_datasize", 32'(data_tx_datasize_o), 32'd2);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Three words, back-to-back grants, data one cycle after grant.
        rdy_mode = 1; seq_mode = 1'b1; seq_base = 32'hA0;
        start_read(3);
        finish_read("three", 3);
        seq_mode = 1'b0;

        // Credit limit: downstream stalled, only DEPTH grants may go out.
        rdy_mode = 0;
        start_read(10);
        repeat (20) @(negedge clk_i);
        #1;
        check("stall_grants", 32'(txn_grants), 32'(DEPTH));
        check("stall_req", 32'(data_tx_req_o), 32'd0);
        rdy_mode = 1;
        finish_read("ten", 10);

        // Zero-length read: done one cycle after start, no requests.
        start_read(0);
        finish_read("zero", 0);
        check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd1);

        // Abort after 3 grants with data still owed.
        rdy_mode = 0; gnt_cap = 3; dly_min = 2; dly_max = 2;
        start_read(8);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            #2;
            if (txn_grants == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_three_grants", 32'(ok), 32'd1);
        @(negedge clk_i);
        abort_i = 1'b1;
        discard = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        abort_i  = 1'b0;
        flushing = 1'b1;
        #1;
        check("flush_busy", 32'(busy_o), 32'd1);
        check("flush_req", 32'(data_tx_req_o), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            #2;
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        flushing = 1'b0;
        check("flush_to_idle", 32'(ok), 32'd1);
        check("flush_no_done", 32'(done_cnt - d0), 32'd0);
        check("flush_pending", 32'(pend_q.size()), 32'd0);
        $display("[TB] read abort: cnt=8 grants=%0d discarded", txn_grants);
        gnt_cap = 1 << 30; dly_min = 1; dly_max = 1; rdy_mode = 1;
        start_read(4);
        finish_read("after_abort", 4);

        // Start while busy is ignored.
        start_read(2);
        @(negedge clk_i);
        start_i    = 1'b1;
        word_cnt_i = TS'(5);
        #1;
        check("busy_restart_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        start_i = 1'b0;
        finish_read("busy_start", 2);

        // Asynchronous reset in the middle of a stalled read.
        rdy_mode = 0;
        start_read(10);
        repeat (6) @(negedge clk_i);
        rst_ni = 1'b0;
        pend_q.delete();
        exp_q.delete();
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_req", 32'(data_tx_req_o), 32'd0);
        check("arst_valid", 32'(trdb_word_valid_o), 32'd0);
        repeat (2) @(negedge clk_i);
        tot_pops = 0;
        rst_ni   = 1'b1;
        $display("[TB] read reset_mid: cnt=10 grants=%0d aborted by reset", txn_grants);
        @(negedge clk_i);

        // Randomized reads with random grant, latency and backpressure.
        gnt_mode = 1; dly_min = 1; dly_max = 3; rdy_mode = 2;
        for (int t = 0; t < 12; t++) begin
            int cnt;
            cnt = $urandom_range(1, 25);
            start_read(cnt);
            finish_read($sformatf("rand%0d", t), cnt);
        end

`ifdef TRACER_RD_STATS_EN
        check("stat_words", stat_words_o, 32'(tot_pops));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
